// File: rtl/vx_nc_mem_tracker.sv
// Non-cacheable memory tracker: registered request/response paths through 2-entry
// elastic buffers, outstanding NC read limiting, NC-idle flag and stall statistics.

module vx_nc_mem_tracker_buf #(
    parameter int W        = 8,
    parameter int FLAG_BIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i,
    output logic         flag_held_o
);
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign valid_o     = (cnt_q != 2'd0);
    assign full_o      = (cnt_q == 2'd2);
    assign data_o      = head_q;
    assign pop         = valid_o && ready_i;
    assign flag_held_o = (valid_o && head_q[FLAG_BIT]) || (full_o && tail_q[FLAG_BIT]);

    // Outputs always come from head_q; tail_q only holds the second entry while full.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d = data_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end
endmodule

module vx_nc_mem_tracker #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_SIZE  = 64,
    parameter int MEM_DATA_WIDTH = MEM_DATA_SIZE * 8,
    parameter int MEM_TAG_WIDTH  = 8,
    parameter int NC_TAG_BIT     = 0,
    parameter int MAX_PENDING    = 4,
    localparam int CNTW          = $clog2(MAX_PENDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_req_valid_in,
    input  logic                      mem_req_rw_in,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_in,
    input  logic [MEM_DATA_SIZE-1:0]  mem_req_byteen_in,
    input  logic [MEM_DATA_WIDTH-1:0] mem_req_data_in,
    input  logic [MEM_TAG_WIDTH-1:0]  mem_req_tag_in,
    output logic                      mem_req_ready_in,
    output logic                      mem_req_valid_out,
    output logic                      mem_req_rw_out,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_out,
    output logic [MEM_DATA_SIZE-1:0]  mem_req_byteen_out,
    output logic [MEM_DATA_WIDTH-1:0] mem_req_data_out,
    output logic [MEM_TAG_WIDTH-1:0]  mem_req_tag_out,
    input  logic                      mem_req_ready_out,
    input  logic                      mem_rsp_valid_in,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_in,
    input  logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag_in,
    output logic                      mem_rsp_ready_in,
    output logic                      mem_rsp_valid_out,
    output logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_out,
    output logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag_out,
    input  logic                      mem_rsp_ready_out,
    output logic [CNTW-1:0]           nc_pending_count,
    output logic                      nc_idle,
    output logic [31:0]               nc_stall_cycles
);
    localparam int REQ_W = 1 + MEM_ADDR_WIDTH + MEM_DATA_SIZE + MEM_DATA_WIDTH + MEM_TAG_WIDTH;
    localparam int RSP_W = MEM_DATA_WIDTH + MEM_TAG_WIDTH;

    logic [REQ_W-1:0] req_in, req_out;
    logic [RSP_W-1:0] rsp_in, rsp_out;
    logic             req_full, rsp_full;
    logic             req_nc_held, rsp_nc_held;
    logic             is_nc_rd, at_limit, limit_block;
    logic             nc_inc, nc_dec, nc_underflow;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [31:0]      stall_q, stall_d;

    // Tag sits in the low bits of both packed words so FLAG_BIT addresses the NC bit.
    assign req_in = {mem_req_rw_in, mem_req_addr_in, mem_req_byteen_in, mem_req_data_in, mem_req_tag_in};
    assign {mem_req_rw_out, mem_req_addr_out, mem_req_byteen_out, mem_req_data_out, mem_req_tag_out} = req_out;
    assign rsp_in = {mem_rsp_data_in, mem_rsp_tag_in};
    assign {mem_rsp_data_out, mem_rsp_tag_out} = rsp_out;

    assign is_nc_rd = mem_req_tag_in[NC_TAG_BIT] && !mem_req_rw_in;
    assign nc_dec   = mem_rsp_valid_out && mem_rsp_ready_out && mem_rsp_tag_out[NC_TAG_BIT];
    assign at_limit = (cnt_q == CNTW'(MAX_PENDING));

    // A response retiring this cycle frees a slot, so a waiting NC read may take it at once.
    assign limit_block      = mem_req_valid_in && is_nc_rd && at_limit && !nc_dec;
    assign mem_req_ready_in = !reset && !req_full && !limit_block;
    assign mem_rsp_ready_in = !reset && !rsp_full;
    assign nc_inc           = mem_req_valid_in && mem_req_ready_in && is_nc_rd;
    assign nc_underflow     = nc_dec && !nc_inc && (cnt_q == '0);

    vx_nc_mem_tracker_buf #(.W(REQ_W), .FLAG_BIT(NC_TAG_BIT)) u_req_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (mem_req_valid_in && mem_req_ready_in),
        .data_i      (req_in),
        .full_o      (req_full),
        .valid_o     (mem_req_valid_out),
        .data_o      (req_out),
        .ready_i     (mem_req_ready_out),
        .flag_held_o (req_nc_held)
    );

    vx_nc_mem_tracker_buf #(.W(RSP_W), .FLAG_BIT(NC_TAG_BIT)) u_rsp_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (mem_rsp_valid_in && mem_rsp_ready_in),
        .data_i      (rsp_in),
        .full_o      (rsp_full),
        .valid_o     (mem_rsp_valid_out),
        .data_o      (rsp_out),
        .ready_i     (mem_rsp_ready_out),
        .flag_held_o (rsp_nc_held)
    );

    always_comb begin
        cnt_d = cnt_q;
        case ({nc_inc, nc_dec})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
        stall_d = stall_q;
        if (limit_block && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!nc_underflow)
                else $warning("vx_nc_mem_tracker: NC response returned with no NC read outstanding");
        end
    end

    assign nc_pending_count = cnt_q;
    assign nc_stall_cycles  = stall_q;
    assign nc_idle          = (cnt_q == '0) && !req_nc_held && !rsp_nc_held;
endmodule

// File: tb/tb_vx_nc_mem_tracker.sv
// Bench for vx_nc_mem_tracker: request/response scoreboards plus a vector table
// and directed sequences around the NC read limit, backpressure and reset.

module tb_vx_nc_mem_tracker;
    localparam int AW = 32, DS = 64, DW = 512, TW = 8, NCB = 0, MAXP = 4, CNTW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mem_req_valid_in, mem_req_rw_in, mem_req_ready_in;
    logic [AW-1:0] mem_req_addr_in;
    logic [DS-1:0] mem_req_byteen_in;
    logic [DW-1:0] mem_req_data_in;
    logic [TW-1:0] mem_req_tag_in;
    logic          mem_req_valid_out, mem_req_rw_out, mem_req_ready_out;
    logic [AW-1:0] mem_req_addr_out;
    logic [DS-1:0] mem_req_byteen_out;
    logic [DW-1:0] mem_req_data_out;
    logic [TW-1:0] mem_req_tag_out;
    logic          mem_rsp_valid_in, mem_rsp_ready_in;
    logic [DW-1:0] mem_rsp_data_in;
    logic [TW-1:0] mem_rsp_tag_in;
    logic          mem_rsp_valid_out, mem_rsp_ready_out;
    logic [DW-1:0] mem_rsp_data_out;
    logic [TW-1:0] mem_rsp_tag_out;
    logic [CNTW-1:0] nc_pending_count;
    logic          nc_idle;
    logic [31:0]   nc_stall_cycles;

    vx_nc_mem_tracker #(
        .MEM_ADDR_WIDTH(AW), .MEM_DATA_SIZE(DS), .MEM_DATA_WIDTH(DW),
        .MEM_TAG_WIDTH(TW), .NC_TAG_BIT(NCB), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid_in(mem_req_valid_in), .mem_req_rw_in(mem_req_rw_in),
        .mem_req_addr_in(mem_req_addr_in), .mem_req_byteen_in(mem_req_byteen_in),
        .mem_req_data_in(mem_req_data_in), .mem_req_tag_in(mem_req_tag_in),
        .mem_req_ready_in(mem_req_ready_in),
        .mem_req_valid_out(mem_req_valid_out), .mem_req_rw_out(mem_req_rw_out),
        .mem_req_addr_out(mem_req_addr_out), .mem_req_byteen_out(mem_req_byteen_out),
        .mem_req_data_out(mem_req_data_out), .mem_req_tag_out(mem_req_tag_out),
        .mem_req_ready_out(mem_req_ready_out),
        .mem_rsp_valid_in(mem_rsp_valid_in), .mem_rsp_data_in(mem_rsp_data_in),
        .mem_rsp_tag_in(mem_rsp_tag_in), .mem_rsp_ready_in(mem_rsp_ready_in),
        .mem_rsp_valid_out(mem_rsp_valid_out), .mem_rsp_data_out(mem_rsp_data_out),
        .mem_rsp_tag_out(mem_rsp_tag_out), .mem_rsp_ready_out(mem_rsp_ready_out),
        .nc_pending_count(nc_pending_count), .nc_idle(nc_idle),
        .nc_stall_cycles(nc_stall_cycles)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [TW-1:0] tag;
        logic [DS-1:0] be;
        logic [DW-1:0] data;
        int            cyc;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [TW-1:0] tag;
        int            exp_cnt;
        logic          exp_idle;
    } vec_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t re;
    rsp_t rr;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboards: entries are pushed when an input handshake is about to happen on
    // the coming edge and popped when the corresponding output handshake is.
    always @(negedge clk) begin
        if (reset) begin
            req_q.delete();
            rsp_q.delete();
        end else begin
            if (mem_req_valid_out && mem_req_ready_out) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected_output", 64'd1, 64'd0);
                end else begin
                    re = req_q.pop_front();
                    chk("req_addr", mem_req_addr_out, re.addr);
                    chk("req_rw", mem_req_rw_out, re.rw);
                    chk("req_tag", mem_req_tag_out, re.tag);
                    chk("req_byteen", mem_req_byteen_out, re.be);
                    chk("req_data_match", mem_req_data_out === re.data, 1);
                    if (chk_lat) chk("req_latency", 64'(cyc - re.cyc), 64'd1);
                end
            end
            if (mem_req_valid_in && mem_req_ready_in)
                req_q.push_back('{addr: mem_req_addr_in, rw: mem_req_rw_in, tag: mem_req_tag_in,
                                  be: mem_req_byteen_in, data: mem_req_data_in, cyc: cyc});
            if (mem_rsp_valid_out && mem_rsp_ready_out) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected_output", 64'd1, 64'd0);
                end else begin
                    rr = rsp_q.pop_front();
                    chk("rsp_tag", mem_rsp_tag_out, rr.tag);
                    chk("rsp_data_match", mem_rsp_data_out === rr.data, 1);
                end
            end
            if (mem_rsp_valid_in && mem_rsp_ready_in)
                rsp_q.push_back('{data: mem_rsp_data_in, tag: mem_rsp_tag_in});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic rw, input logic [TW-1:0] tag);
        mem_req_valid_in  = 1'b1;
        mem_req_addr_in   = a;
        mem_req_rw_in     = rw;
        mem_req_tag_in    = tag;
        mem_req_byteen_in = {~a, a};
        mem_req_data_in   = {16{a ^ 32'h5A5A_0000}};
    endtask

    task automatic wait_req_accept(output int waits);
        waits = 0;
        @(negedge clk);
        while (!mem_req_ready_in && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!mem_req_ready_in) chk("req_accept_timeout", 64'd0, 64'd1);
        tick();
        mem_req_valid_in = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic rw, input logic [TW-1:0] tag, output int waits);
        drive_req(a, rw, tag);
        wait_req_accept(waits);
    endtask

    task automatic drive_rsp(input logic [31:0] d, input logic [TW-1:0] tag);
        mem_rsp_valid_in = 1'b1;
        mem_rsp_data_in  = {16{d}};
        mem_rsp_tag_in   = tag;
    endtask

    task automatic rsp_send(input logic [31:0] d, input logic [TW-1:0] tag);
        int n;
        n = 0;
        drive_rsp(d, tag);
        @(negedge clk);
        while (!mem_rsp_ready_in && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!mem_rsp_ready_in) chk("rsp_accept_timeout", 64'd0, 64'd1);
        tick();
        mem_rsp_valid_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_valid_out"}, mem_req_valid_out, 0);
        chk({tag, "_rsp_valid_out"}, mem_rsp_valid_out, 0);
        chk({tag, "_count"}, nc_pending_count, 0);
        chk({tag, "_idle"}, nc_idle, 1);
        chk({tag, "_stall"}, nc_stall_cycles, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end in time");
        $fatal(1, "watchdog expired");
    end

    vec_t vt[12];
    int   w;

    initial begin
        reset = 1'b1;
        mem_req_valid_in = 1'b0; mem_req_rw_in = 1'b0; mem_req_addr_in = '0;
        mem_req_byteen_in = '0; mem_req_data_in = '0; mem_req_tag_in = '0;
        mem_req_ready_out = 1'b1;
        mem_rsp_valid_in = 1'b0; mem_rsp_data_in = '0; mem_rsp_tag_in = '0;
        mem_rsp_ready_out = 1'b1;

        for (int i = 0; i < 8; i++) vt[i] = '{addr: 32'h100 + i, rw: 1'b0, tag: 8'h02, exp_cnt: 0, exp_idle: 1'b1};
        vt[8]  = '{addr: 32'h200, rw: 1'b1, tag: 8'h01, exp_cnt: 0, exp_idle: 1'b0};
        vt[9]  = '{addr: 32'h201, rw: 1'b0, tag: 8'h01, exp_cnt: 1, exp_idle: 1'b0};
        vt[10] = '{addr: 32'h202, rw: 1'b0, tag: 8'h03, exp_cnt: 2, exp_idle: 1'b0};
        vt[11] = '{addr: 32'h203, rw: 1'b1, tag: 8'h00, exp_cnt: 2, exp_idle: 1'b0};

        repeat (3) tick();
        @(negedge clk);
        chk("reset_req_ready_in", mem_req_ready_in, 0);
        chk("reset_rsp_ready_in", mem_rsp_ready_in, 0);
        tick();
        reset = 1'b0;
        check_reset_state("init");

        // Back-to-back non-NC reads, then a mix of NC writes/reads and plain writes.
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vt[i].addr, vt[i].rw, vt[i].tag, w);
            chk("vec_accept_waits", w, 0);
            chk("vec_count", nc_pending_count, vt[i].exp_cnt);
            chk("vec_idle", nc_idle, vt[i].exp_idle);
        end
        tick();
        chk_lat = 1'b0;
        chk("vec_req_drained", req_q.size(), 0);
        rsp_send(32'hD001, 8'h01);
        rsp_send(32'hD002, 8'h03);
        repeat (2) tick();
        chk("vec_rsp_count", nc_pending_count, 0);
        chk("vec_rsp_idle", nc_idle, 1);
        chk("vec_rsp_drained", rsp_q.size(), 0);

        // Four NC reads fill the limit; the fifth is held off.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst2");
        for (int i = 0; i < 4; i++) send(32'h300 + i, 1'b0, 8'h01, w);
        chk("limit_count", nc_pending_count, 4);
        drive_req(32'h304, 1'b0, 8'h01);
        @(negedge clk);
        chk("limit_ready_in", mem_req_ready_in, 0);
        chk("limit_stall_start", nc_stall_cycles, 0);
        repeat (3) @(negedge clk);
        chk("limit_stall_3", nc_stall_cycles, 3);
        chk("limit_ready_in_held", mem_req_ready_in, 0);

        // One NC response retires; the waiting read goes in on that very edge.
        tick();
        drive_rsp(32'hA5, 8'h01);
        @(negedge clk);
        chk("ret_rsp_ready_in", mem_rsp_ready_in, 1);
        chk("ret_req_still_blocked", mem_req_ready_in, 0);
        tick();
        mem_rsp_valid_in = 1'b0;
        @(negedge clk);
        chk("ret_req_ready_in", mem_req_ready_in, 1);
        chk("ret_rsp_valid_out", mem_rsp_valid_out, 1);
        tick();
        mem_req_valid_in = 1'b0;
        chk("ret_count", nc_pending_count, 4);

        // NC writes are never limited.
        send(32'h400, 1'b1, 8'h01, w);
        chk("ncw_waits", w, 0);
        chk("ncw_count", nc_pending_count, 4);

        // Back to 2, then NC read accept and NC response retire on the same edge.
        rsp_send(32'hB1, 8'h01);
        rsp_send(32'hB2, 8'h01);
        repeat (2) tick();
        chk("same_pre_count", nc_pending_count, 2);
        drive_rsp(32'hC1, 8'h01);
        tick();
        mem_rsp_valid_in = 1'b0;
        drive_req(32'h500, 1'b0, 8'h01);
        @(negedge clk);
        chk("same_req_ready_in", mem_req_ready_in, 1);
        chk("same_rsp_valid_out", mem_rsp_valid_out, 1);
        tick();
        mem_req_valid_in = 1'b0;
        chk("same_count", nc_pending_count, 2);

        // Request backpressure: two entries buffer, the third waits, all drain in order.
        tick();
        mem_req_ready_out = 1'b0;
        drive_req(32'h600, 1'b0, 8'h02);
        @(negedge clk);
        chk("bp_ready_0", mem_req_ready_in, 1);
        tick();
        drive_req(32'h601, 1'b0, 8'h02);
        @(negedge clk);
        chk("bp_ready_1", mem_req_ready_in, 1);
        tick();
        drive_req(32'h602, 1'b0, 8'h02);
        @(negedge clk);
        chk("bp_full_ready", mem_req_ready_in, 0);
        chk("bp_head_addr", mem_req_addr_out, 32'h600);
        tick();
        mem_req_ready_out = 1'b1;
        wait_req_accept(w);
        repeat (3) tick();
        chk("bp_drained", req_q.size(), 0);

        // Response backpressure.
        mem_rsp_ready_out = 1'b0;
        rsp_send(32'hE0, 8'h02);
        rsp_send(32'hE1, 8'h02);
        drive_rsp(32'hE2, 8'h02);
        @(negedge clk);
        chk("rbp_full_ready", mem_rsp_ready_in, 0);
        chk("rbp_head_tag", mem_rsp_tag_out, 8'h02);
        tick();
        mem_rsp_ready_out = 1'b1;
        mem_rsp_valid_in = 1'b0;
        rsp_send(32'hE2, 8'h02);
        repeat (3) tick();
        chk("rbp_drained", rsp_q.size(), 0);
        chk("rbp_count", nc_pending_count, 2);

        // Reset with two requests buffered and three NC reads outstanding.
        send(32'h700, 1'b0, 8'h01, w);
        tick();
        mem_req_ready_out = 1'b0;
        send(32'h701, 1'b0, 8'h02, w);
        send(32'h702, 1'b0, 8'h02, w);
        chk("pre_rst_count", nc_pending_count, 3);
        chk("pre_rst_valid_out", mem_req_valid_out, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready_in", mem_req_ready_in, 0);
        chk("mid_rst_rsp_ready_in", mem_rsp_ready_in, 0);
        tick();
        reset = 1'b0;
        mem_req_ready_out = 1'b1;
        check_reset_state("rst3");

        // Spurious NC response at zero count.
        drive_rsp(32'hF1, 8'h01);
        tick();
        mem_rsp_valid_in = 1'b0;
        @(negedge clk);
        chk("spur_underflow_flag", dut.nc_underflow, 1);
        chk("spur_count_before", nc_pending_count, 0);
        chk("spur_idle_held", nc_idle, 0);
        tick();
        chk("spur_count_after", nc_pending_count, 0);
        tick();
        chk("spur_idle_after", nc_idle, 1);
        chk("final_req_q", req_q.size(), 0);
        chk("final_rsp_q", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
